// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accel_pkg
// Purpose  : Shared accelerator definitions: sequencer state indices and the
//            tile descriptor.
// Revision : 1.0  initial release
// ============================================================================
package accel_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STREAM  = 3'd2,
        S_TAIL    = 3'd3,
        S_IMG2COL = 3'd4,
        S_END     = 3'd5
    } state_idx_e;

    localparam int STATE_W       = 6;
    localparam int c_desc_addr_w = 16;
    localparam int c_desc_k_w    = 16;

    typedef struct packed {
        logic [c_desc_addr_w-1:0] weight_base;
        logic [c_desc_addr_w-1:0] act_base;
        logic [c_desc_k_w-1:0]    k_len;
    } tile_desc_t;

    function automatic logic [STATE_W-1:0] state_onehot(input state_idx_e s);
        return STATE_W'(1) << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_down_counter
// Purpose  : Loadable, enable-gated down-counter that stops at zero.
// Revision : 1.0  initial release
// ============================================================================
module seq_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tile_sequencer
// Purpose  : Walks one systolic tile through LOAD, STREAM, TAIL and END,
//            issuing parameter-RAM reads and array strobes.
//            TILE_SEQ_PERF_EN adds saturating busy/stall counters.
// Revision : 1.0  initial release
// ============================================================================
module tile_sequencer
    import accel_pkg::*;
#(
    parameter int ARRAY_N = 8,
    parameter int ADDR_W  = 16,
    parameter int K_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  weight_base,
    input  logic [ADDR_W-1:0]  act_base,
    input  logic [K_W-1:0]     k_len,
    input  logic               stream_ready,
    output logic               ram_en,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               weight_shift,
    output logic               act_valid,
    output logic               drain_en,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] curr_state
`ifdef TILE_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_stalls
`endif
);

    localparam int c_load_w = $clog2(ARRAY_N) + 1;
    localparam int c_tail_w = $clog2(2 * ARRAY_N) + 1;

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_state_nxt;
    tile_desc_t          r_desc;
    logic                w_start_acc;
    logic                w_enter_tail;
    logic [c_load_w-1:0] w_load_cnt;
    logic                w_load_zero;
    logic [K_W-1:0]      w_strm_cnt;
    logic                w_strm_zero;
    logic [c_tail_w-1:0] w_tail_cnt_unused;
    logic                w_tail_zero;
    logic [ADDR_W-1:0]   w_load_off;
    logic [K_W-1:0]      w_strm_j;
    logic                r_weight_shift;
    logic                r_act_valid;

    assign w_start_acc  = r_state[S_IDLE] && start && !abort;
    assign w_enter_tail = w_state_nxt[S_TAIL] && !r_state[S_TAIL];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= state_onehot(S_IDLE);
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            r_state[S_IDLE]: begin
                if (start) w_state_nxt = state_onehot(S_LOAD);
            end
            r_state[S_LOAD]: begin
                if (w_load_zero) begin
                    w_state_nxt = (r_desc.k_len != '0) ? state_onehot(S_STREAM)
                                                       : state_onehot(S_TAIL);
                end
            end
            r_state[S_STREAM]: begin
                if (stream_ready && w_strm_zero) w_state_nxt = state_onehot(S_TAIL);
            end
            r_state[S_TAIL]: begin
                if (w_tail_zero) w_state_nxt = state_onehot(S_END);
            end
            r_state[S_END]: begin
                w_state_nxt = state_onehot(S_IDLE);
            end
            default: begin
                w_state_nxt = state_onehot(S_IDLE);
            end
        endcase
        if (abort) w_state_nxt = state_onehot(S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_desc <= '0;
        end else if (w_start_acc) begin
            r_desc.weight_base <= c_desc_addr_w'(weight_base);
            r_desc.act_base    <= c_desc_addr_w'(act_base);
            r_desc.k_len       <= c_desc_k_w'(k_len);
        end
    end

    // Each counter holds the reads still to issue after the current one.
    seq_down_counter #(.WIDTH(c_load_w)) u_load_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (abort),
        .i_load     (w_start_acc),
        .i_load_val (c_load_w'(ARRAY_N - 1)),
        .i_en       (r_state[S_LOAD]),
        .o_count    (w_load_cnt),
        .o_zero     (w_load_zero)
    );

    seq_down_counter #(.WIDTH(K_W)) u_strm_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (abort),
        .i_load     (w_start_acc),
        .i_load_val (k_len - K_W'(1)),
        .i_en       (r_state[S_STREAM] && stream_ready),
        .o_count    (w_strm_cnt),
        .o_zero     (w_strm_zero)
    );

    seq_down_counter #(.WIDTH(c_tail_w)) u_tail_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (abort),
        .i_load     (w_enter_tail),
        .i_load_val (c_tail_w'(2 * ARRAY_N - 2)),
        .i_en       (r_state[S_TAIL]),
        .o_count    (w_tail_cnt_unused),
        .o_zero     (w_tail_zero)
    );

    // Offsets are recovered from the remaining counts; adds wrap at 2^ADDR_W.
    assign w_load_off = ADDR_W'(ARRAY_N - 1) - ADDR_W'(w_load_cnt);
    assign w_strm_j   = K_W'(r_desc.k_len) - K_W'(1) - w_strm_cnt;

    always_comb begin
        ram_en   = 1'b0;
        ram_addr = '0;
        if (r_state[S_LOAD]) begin
            ram_en   = 1'b1;
            ram_addr = ADDR_W'(r_desc.weight_base) + w_load_off;
        end else if (r_state[S_STREAM] && stream_ready) begin
            ram_en   = 1'b1;
            ram_addr = ADDR_W'(r_desc.act_base) + ADDR_W'(w_strm_j);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_weight_shift <= 1'b0;
            r_act_valid    <= 1'b0;
        end else begin
            r_weight_shift <= r_state[S_LOAD];
            r_act_valid    <= r_state[S_STREAM] && stream_ready;
        end
    end

    assign weight_shift = r_weight_shift;
    assign act_valid    = r_act_valid;
    assign drain_en     = r_state[S_TAIL];
    assign busy         = !r_state[S_IDLE];
    assign done         = r_state[S_END];
    assign curr_state   = r_state;

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_start_acc) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (!r_state[S_IDLE]) begin
            if (r_perf_cycles != 32'hFFFF_FFFF) r_perf_cycles <= r_perf_cycles + 32'd1;
            if (r_state[S_STREAM] && !stream_ready && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`else
    // Without the performance option the sequencer carries no counters.
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_sequencer
// Purpose  : Randomised self-checking bench for tile_sequencer against a
//            tile-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tile_sequencer;
    import accel_pkg::*;

    localparam int ARRAY_N = 8;
    localparam int ADDR_W  = 16;
    localparam int K_W     = 16;
    localparam int MAXC    = 300;

    logic               clk = 1'b0;
    logic               rst, start, abort, stream_ready;
    logic [ADDR_W-1:0]  weight_base, act_base;
    logic [K_W-1:0]     k_len;
    logic               ram_en, weight_shift, act_valid, drain_en, busy, done;
    logic [ADDR_W-1:0]  ram_addr;
    logic [STATE_W-1:0] curr_state;
`ifdef TILE_SEQ_PERF_EN
    logic [31:0]        perf_cycles, perf_stalls;
`endif

    tile_sequencer #(.ARRAY_N(ARRAY_N), .ADDR_W(ADDR_W), .K_W(K_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .weight_base  (weight_base),
        .act_base     (act_base),
        .k_len        (k_len),
        .stream_ready (stream_ready),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .weight_shift (weight_shift),
        .act_valid    (act_valid),
        .drain_en     (drain_en),
        .busy         (busy),
        .done         (done),
        .curr_state   (curr_state)
`ifdef TILE_SEQ_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0 in stream
    task automatic run_tile(input logic [15:0] wb, input logic [15:0] ab, input int k,
                            input int mode, input int restart_at, input string name);
        logic [15:0] exp_q[$];
        logic [15:0] got_q[$];
        bit          rdy_hist [0:MAXC-1];
        int ws = 0, av = 0, dr = 0, bz = 0, dn = 0;
        int done_c = -1, stalls = 0, ones = 0, c = 0, cc;
        for (int i = 0; i < ARRAY_N; i++) exp_q.push_back(wb + 16'(i));
        for (int j = 0; j < k; j++) exp_q.push_back(ab + 16'(j));

        @(negedge clk);
        weight_base = wb; act_base = ab; k_len = 16'(k);
        start = 1'b1; stream_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (c < MAXC) begin
            weight_base = 16'($urandom);
            act_base    = 16'($urandom);
            k_len       = 16'($urandom);
            case (mode)
                0:       stream_ready = 1'b1;
                1:       stream_ready = 1'($urandom_range(0, 1));
                default: stream_ready = (c >= ARRAY_N) ? ((c - ARRAY_N) % 3 == 0) : 1'b0;
            endcase
            start = (c == restart_at);
            rdy_hist[c] = stream_ready;
            #1;
            if (ram_en) got_q.push_back(ram_addr);
            ws += int'(weight_shift);
            av += int'(act_valid);
            dr += int'(drain_en);
            bz += int'(busy);
            dn += int'(done);
            if (done && done_c < 0) done_c = c;
            if (done_c >= 0 && c == done_c + 1) begin
                chk({name, "_idle_after_done"}, 32'(curr_state), 32'(1) << S_IDLE);
                chk({name, "_busy_after_done"}, 32'(busy), 32'd0);
                break;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;

        cc = ARRAY_N;
        while (ones < k && cc < MAXC) begin
            if (rdy_hist[cc]) ones++;
            else stalls++;
            cc++;
        end

        chk({name, "_finished"}, 32'(done_c >= 0), 32'd1);
        chk({name, "_done_cycle"}, 32'(done_c), 32'(2 * ARRAY_N + ARRAY_N + k + stalls - 1));
        chk({name, "_n_reads"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_addr%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({name, "_weight_shift"}, 32'(ws), 32'(ARRAY_N));
        chk({name, "_act_valid"}, 32'(av), 32'(k));
        chk({name, "_drain"}, 32'(dr), 32'(2 * ARRAY_N - 1));
        chk({name, "_done_pulses"}, 32'(dn), 32'd1);
        chk({name, "_busy_cycles"}, 32'(bz), 32'(3 * ARRAY_N + k + stalls));
`ifdef TILE_SEQ_PERF_EN
        chk({name, "_perf_cycles"}, perf_cycles, 32'(3 * ARRAY_N + k + stalls));
        chk({name, "_perf_stalls"}, perf_stalls, 32'(stalls));
`endif
    endtask

    initial begin
        int av, dn;
        rst = 1'b1; start = 1'b0; abort = 1'b0; stream_ready = 1'b0;
        weight_base = '0; act_base = '0; k_len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state", 32'(curr_state), 32'(1) << S_IDLE);
        chk("reset_outputs", {25'd0, ram_en, weight_shift, act_valid, drain_en, busy, done, |ram_addr}, 32'd0);

        run_tile(16'h0100, 16'h0200, 4, 0, -1, "basic");
        run_tile(16'h0300, 16'h0400, 0, 0, -1, "k0");
        run_tile(16'h0500, 16'h0600, 3, 2, -1, "stall");
        run_tile(16'h1000, 16'hFFFE, 4, 0, -1, "wrap");
        for (int t = 0; t < 4; t++)
            run_tile(16'($urandom), 16'($urandom), $urandom_range(0, 12), 1,
                     (t == 0) ? 3 : ((t == 1) ? 12 : -1), $sformatf("rnd%0d", t));

        // abort in the third stream cycle
        @(negedge clk);
        weight_base = 16'h2000; act_base = 16'h3000; k_len = 16'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0; stream_ready = 1'b1;
        repeat (ARRAY_N + 2) @(negedge clk);
        #1;
        chk("abort_in_stream", 32'(curr_state), 32'(1) << S_STREAM);
        abort = 1'b1;
        av = 0; dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            abort = 1'b0;
            #1;
            if (i == 0) begin
                chk("abort_idle", 32'(curr_state), 32'(1) << S_IDLE);
                chk("abort_busy", 32'(busy), 32'd0);
            end
            av += int'(act_valid);
            dn += int'(done);
        end
        chk("abort_trailing_av", 32'(av <= 1), 32'd1);
        chk("abort_no_done", 32'(dn), 32'd0);

        // abort and start together in idle
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        chk("abort_start_idle", 32'(curr_state), 32'(1) << S_IDLE);
        @(negedge clk);
        #1;
        chk("abort_start_stay", 32'(busy), 32'd0);

        run_tile(16'h4000, 16'h5000, 5, 1, -1, "post_abort");

        // reset pulse mid-TAIL
        @(negedge clk);
        weight_base = 16'h6000; act_base = 16'h7000; k_len = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; stream_ready = 1'b1;
        repeat (ARRAY_N + 2 + 5) @(negedge clk);
        #1;
        chk("rst_in_tail", 32'(curr_state), 32'(1) << S_TAIL);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(curr_state), 32'(1) << S_IDLE);
        chk("rst_outputs", {25'd0, ram_en, weight_shift, act_valid, drain_en, busy, done, |ram_addr}, 32'd0);

        run_tile(16'hFFFC, 16'h0010, 7, 1, -1, "post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
